axi_write_engine: RTL and testbench

- Parametrised successor to the single-shot write submodule.
- Accepts a stream of (address, data) write commands into an internal command FIFO.
- Drives the memory AW/W/B channels with AW and W handshaking independently, and keeps up to MAX_OUTSTANDING writes in flight awaiting B.
- Reports each B response to the supermodule as a one-cycle done pulse with resp, and keeps a saturating error count.

---
 rtl/axi_write_engine.sv | 152 +++++++++++++++
 tb/tb_axi_write_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_write_engine.sv
// Queued AXI-style write engine: a command FIFO feeds independent AW/W handshakes, with up to MAX_OUTSTANDING writes awaiting B.
// Optional write strobes are enabled by defining AXI_WRITE_ENGINE_WSTRB_EN.
module axi_write_engine #(
  parameter int unsigned ADDR_WDTH       = 4,
  parameter int unsigned DATA_WDTH       = 32,
  parameter int unsigned RESP_WDTH       = 2,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned ERRCNT_WDTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_WDTH-1:0]   cmd_addr,
  input  logic [DATA_WDTH-1:0]   cmd_data,
`ifdef AXI_WRITE_ENGINE_WSTRB_EN
  input  logic [DATA_WDTH/8-1:0] cmd_strb,
  output logic [DATA_WDTH/8-1:0] w_strb,
`endif
  output logic                   aw_valid,
  input  logic                   aw_ready,
  output logic [ADDR_WDTH-1:0]   aw_address,
  output logic                   w_valid,
  input  logic                   w_ready,
  output logic [DATA_WDTH-1:0]   w_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [RESP_WDTH-1:0]   b_resp,
  output logic                   done,
  output logic [RESP_WDTH-1:0]   resp,
  output logic                   idle,
  output logic [ERRCNT_WDTH-1:0] err_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ISSUE_IDLE, ISSUE_ACTIVE} issue_state_t;

  issue_state_t state, state_nxt;

  logic [ADDR_WDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WDTH-1:0] data_mem [DEPTH];
`ifdef AXI_WRITE_ENGINE_WSTRB_EN
  logic [DATA_WDTH/8-1:0] strb_mem [DEPTH];
`endif

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [OUT_W-1:0] outstanding;
  logic             aw_sent, w_sent, aw_sent_nxt, w_sent_nxt;
  logic             full, empty, push, pop, b_hs;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign b_ready   = (outstanding != '0);
  assign b_hs      = b_valid && b_ready;
  assign idle      = empty && (state == ISSUE_IDLE) && (outstanding == '0);

  assign aw_address = addr_mem[rd_ptr];
  assign w_data     = data_mem[rd_ptr];
`ifdef AXI_WRITE_ENGINE_WSTRB_EN
  assign w_strb     = (state == ISSUE_ACTIVE) ? strb_mem[rd_ptr] : '0;
`endif

  // Payload storage needs no reset; occupancy guards every read
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cmd_addr;
      data_mem[wr_ptr] <= cmd_data;
`ifdef AXI_WRITE_ENGINE_WSTRB_EN
      strb_mem[wr_ptr] <= cmd_strb;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ISSUE_IDLE;
      aw_sent <= 1'b0;
      w_sent  <= 1'b0;
    end else begin
      state   <= state_nxt;
      aw_sent <= aw_sent_nxt;
      w_sent  <= w_sent_nxt;
    end
  end

  // Issue FSM: present the head, pop once both AW and W have handshaken
  always_comb begin
    state_nxt   = state;
    aw_valid    = 1'b0;
    w_valid     = 1'b0;
    aw_sent_nxt = aw_sent;
    w_sent_nxt  = w_sent;
    pop         = 1'b0;
    case (state)
      ISSUE_IDLE: begin
        if (!empty && (outstanding < OUT_W'(MAX_OUTSTANDING))) state_nxt = ISSUE_ACTIVE;
      end
      ISSUE_ACTIVE: begin
        aw_valid = !aw_sent;
        w_valid  = !w_sent;
        if (aw_valid && aw_ready) aw_sent_nxt = 1'b1;
        if (w_valid && w_ready)   w_sent_nxt  = 1'b1;
        if (aw_sent_nxt && w_sent_nxt) begin
          pop         = 1'b1;
          aw_sent_nxt = 1'b0;
          w_sent_nxt  = 1'b0;
          state_nxt   = ISSUE_IDLE;
        end
      end
      default: state_nxt = ISSUE_IDLE;
    endcase
  end

  // Response path: outstanding tracking, done pulse and saturating error count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      done        <= 1'b0;
      resp        <= '0;
      err_count   <= '0;
    end else begin
      if (pop && !b_hs)      outstanding <= outstanding + OUT_W'(1);
      else if (b_hs && !pop) outstanding <= outstanding - OUT_W'(1);
      done <= b_hs;
      if (b_hs) begin
        resp <= b_resp;
        if ((b_resp != '0) && (err_count != '1)) err_count <= err_count + ERRCNT_WDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_write_engine.sv
// Directed self-checking bench for axi_write_engine (ERRCNT_WDTH=2 to reach saturation).
// Strobe ports are connected only when AXI_WRITE_ENGINE_WSTRB_EN is defined.
module tb_axi_write_engine;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 2;
  localparam int unsigned EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
`ifdef AXI_WRITE_ENGINE_WSTRB_EN
  logic [DW/8-1:0] cmd_strb, w_strb;
`endif
  logic          aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready;
  logic [AW-1:0] aw_address;
  logic [DW-1:0] w_data;
  logic [RW-1:0] b_resp, resp;
  logic          done, idle;
  logic [EW-1:0] err_count;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int aw_cnt = 0;
  int w_cnt = 0;
  logic [AW-1:0] aw_q [$];

  axi_write_engine #(
    .ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW),
    .DEPTH(4), .MAX_OUTSTANDING(2), .ERRCNT_WDTH(EW)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
`ifdef AXI_WRITE_ENGINE_WSTRB_EN
    .cmd_strb(cmd_strb), .w_strb(w_strb),
`endif
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .done(done), .resp(resp), .idle(idle), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Handshakes are observed mid-cycle, where inputs and outputs are settled
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (aw_valid && aw_ready) begin
        aw_cnt++;
        aw_q.push_back(aw_address);
      end
      if (w_valid && w_ready) w_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int t;
    t = 0;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && t < 50) begin
      step();
      t++;
    end
    check("push_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 200) begin
      step();
      t++;
    end
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic single_write(input logic [AW-1:0] a, input logic [RW-1:0] r);
    int t;
    t = 0;
    push(a, {28'h0, a});
    while (!b_ready && t < 50) begin
      step();
      t++;
    end
    check("bready_wait", 32'(b_ready), 32'd1);
    b_valid = 1'b1;
    b_resp  = r;
    step();
    b_valid = 1'b0;
    check("err_done", 32'(done), 32'd1);
    check("err_resp", 32'(resp), 32'(r));
  endtask

  initial begin
    int aw0, w0, d0;
    logic [AW-1:0] exp_a;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
`ifdef AXI_WRITE_ENGINE_WSTRB_EN
    cmd_strb = '1;
`endif
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_resp = '0;
    #1;
    check("rst_aw_valid", 32'(aw_valid), 32'd0);
    check("rst_w_valid", 32'(w_valid), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    step(); step();
    rst = 1'b0;
    step();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("post_rst_err", 32'(err_count), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);

    // Single write
    aw_ready = 1'b1; w_ready = 1'b1;
    push(4'h3, 32'hDEADBEEF);
    check("t1_not_yet", 32'(aw_valid), 32'd0);
    step();
    check("t1_aw_valid", 32'(aw_valid), 32'd1);
    check("t1_w_valid", 32'(w_valid), 32'd1);
    check("t1_addr", 32'(aw_address), 32'h3);
    check("t1_data", w_data, 32'hDEADBEEF);
    step();
    check("t1_aw_drop", 32'(aw_valid), 32'd0);
    check("t1_b_ready", 32'(b_ready), 32'd1);
    check("t1_busy", 32'(idle), 32'd0);
    b_valid = 1'b1; b_resp = 2'd0;
    step();
    b_valid = 1'b0;
    check("t1_done", 32'(done), 32'd1);
    check("t1_resp", 32'(resp), 32'd0);
    check("t1_b_ready_off", 32'(b_ready), 32'd0);
    step();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle", 32'(idle), 32'd1);
    check("t1_err", 32'(err_count), 32'd0);

    // Split handshakes: W delayed
    aw_ready = 1'b1; w_ready = 1'b0;
    push(4'h5, 32'h12345678);
    step();
    check("t2_aw_valid", 32'(aw_valid), 32'd1);
    check("t2_w_valid", 32'(w_valid), 32'd1);
    step();
    check("t2_aw_drop", 32'(aw_valid), 32'd0);
    check("t2_w_hold", 32'(w_valid), 32'd1);
    step(); step();
    check("t2_w_hold2", 32'(w_valid), 32'd1);
    check("t2_w_data", w_data, 32'h12345678);
    check("t2_no_pop", 32'(b_ready), 32'd0);
    w_ready = 1'b1;
    step();
    check("t2_w_drop", 32'(w_valid), 32'd0);
    check("t2_popped", 32'(b_ready), 32'd1);
    b_valid = 1'b1; b_resp = 2'd0;
    step();
    b_valid = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    step();
    check("t2_idle", 32'(idle), 32'd1);

    // Outstanding limit
    aw_q.delete();
    aw0 = aw_cnt; w0 = w_cnt;
    for (int i = 0; i < 4; i++) push(AW'(i), 32'(i) + 32'hA000);
    repeat (12) step();
    check("t3_aw_issued", 32'(aw_cnt - aw0), 32'd2);
    check("t3_w_issued", 32'(w_cnt - w0), 32'd2);
    check("t3_third_held", 32'(aw_valid), 32'd0);
    check("t3_cmd_ready", 32'(cmd_ready), 32'd1);
    check("t3_b_ready", 32'(b_ready), 32'd1);
    d0 = done_cnt;
    b_valid = 1'b1; b_resp = 2'd0;
    wait_done(d0 + 4);
    b_valid = 1'b0;
    step();
    check("t3_aw_total", 32'(aw_cnt - aw0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      exp_a = AW'(i);
      check("t3_order", 32'(aw_q.size() > 0 ? aw_q.pop_front() : 4'hF), 32'(exp_a));
    end
    check("t3_idle", 32'(idle), 32'd1);

    // FIFO full
    aw_q.delete();
    aw_ready = 1'b0; w_ready = 1'b0;
    for (int i = 8; i < 12; i++) push(AW'(i), 32'(i));
    check("t4_full", 32'(cmd_ready), 32'd0);
    check("t4_head", 32'(aw_address), 32'h8);
    cmd_valid = 1'b1; cmd_addr = 4'hC; cmd_data = 32'hC;
    step(); step();
    check("t4_still_full", 32'(cmd_ready), 32'd0);
    aw_ready = 1'b1; w_ready = 1'b1;
    step();
    check("t4_slot_freed", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    d0 = done_cnt;
    b_valid = 1'b1; b_resp = 2'd0;
    wait_done(d0 + 5);
    b_valid = 1'b0;
    step();
    for (int i = 8; i < 13; i++) begin
      exp_a = AW'(i);
      check("t4_order", 32'(aw_q.size() > 0 ? aw_q.pop_front() : 4'h0), 32'(exp_a));
    end
    check("t4_idle", 32'(idle), 32'd1);

    // Error responses and saturation
    single_write(4'h1, 2'd2);
    single_write(4'h2, 2'd0);
    single_write(4'h3, 2'd2);
    check("t5_err2", 32'(err_count), 32'd2);
    single_write(4'h4, 2'd3);
    check("t5_err3", 32'(err_count), 32'd3);
    single_write(4'h5, 2'd1);
    check("t5_err_sat", 32'(err_count), 32'd3);
    step();
    check("t5_done_low", 32'(done), 32'd0);
    check("t5_resp_hold", 32'(resp), 32'd1);

    // Reset mid-operation
    aw0 = aw_cnt;
    for (int i = 0; i < 3; i++) push(AW'(i + 6), 32'(i));
    repeat (10) step();
    check("t6_two_issued", 32'(aw_cnt - aw0), 32'd2);
    check("t6_b_ready", 32'(b_ready), 32'd1);
    check("t6_busy", 32'(idle), 32'd0);
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    check("t6_rst_aw", 32'(aw_valid), 32'd0);
    check("t6_rst_w", 32'(w_valid), 32'd0);
    check("t6_rst_b_ready", 32'(b_ready), 32'd0);
    check("t6_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    step();
    rst = 1'b0;
    b_valid = 1'b1; b_resp = 2'd2;
    repeat (4) step();
    check("t6_no_done", 32'(done_cnt), 32'(d0));
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_err", 32'(err_count), 32'd0);
    check("t6_no_issue", 32'(aw_valid), 32'd0);
    b_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
